// File: rtl/div_clk_mon.sv
// -----------------------------------------------------------------------------
// div_clk_mon
// Monitors an odd-ratio divided clock in the same clk domain as its source.
// Measures rising-to-rising period and high time in clk cycles, declares lock
// after LOCK_CNT consecutive correct periods, flags period errors and stalls,
// and keeps a saturating error count.
//
// Optional build macro:
//   DIV_MON_DUTY_CHK_EN - when defined, a high time outside {DIV/2, DIV/2+1}
//                         is treated exactly like a period mismatch.
//
// Ports:
//   clk        in   source clock (also drives the divider)
//   rstn       in   asynchronous reset, active-high
//   en         in   monitor enable; 0 forces IDLE and clears lock history
//   clk_div_in in   divided clock under test
//   period     out  last measured period (clk cycles)
//   high_time  out  last measured high time (clk cycles)
//   locked     out  lock status
//   err        out  one-cycle pulse per period/duty mismatch or stall
//   stall      out  sticky stall flag, cleared on next rise or en=0
//   err_cnt    out  saturating error count, cleared only by reset
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | monitor disabled, lock history cleared
// ACQ   | waiting for the first rise; that rise only restarts counters
// MEAS  | measuring periods, good_cnt below LOCK_CNT
// LOCK  | LOCK_CNT consecutive good periods seen, locked=1
// -----------------------------------------------------------------------------
module div_clk_mon #(
    parameter int DIV      = 9,
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clk_div_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             locked,
    output logic             err,
    output logic             stall,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCK} state_t;

    localparam logic [CNT_W-1:0] DIV_C     = CNT_W'(DIV);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(2 * DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;
    localparam logic [3:0]       LOCK_C    = 4'(LOCK_CNT);

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [3:0]       good_cnt;
    logic [3:0]       good_nxt;
    logic             duty_bad;
    logic             meas_bad;

    assign rise = s2 & ~s3;

`ifdef DIV_MON_DUTY_CHK_EN
    localparam logic [CNT_W-1:0] DUTY_LO = CNT_W'(DIV / 2);
    localparam logic [CNT_W-1:0] DUTY_HI = CNT_W'(DIV / 2 + 1);
    // hcnt is frozen since the last fall, so at a rise it holds the previous high time.
    assign duty_bad = (hcnt != DUTY_LO) && (hcnt != DUTY_HI);
`else
    assign duty_bad = 1'b0;
`endif

    assign meas_bad = (pcnt != DIV_C) || duty_bad;
    assign good_nxt = (good_cnt >= LOCK_C) ? LOCK_C : good_cnt + 4'd1;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            pcnt      <= '0;
            hcnt      <= '0;
            good_cnt  <= '0;
            state     <= IDLE;
            period    <= '0;
            high_time <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            stall     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            s1  <= clk_div_in;
            s2  <= s1;
            s3  <= s2;
            err <= 1'b0;

            // Free-running measurement counters; the FSM decides when to use them.
            if (rise)
                pcnt <= CNT_W'(1);
            else if (pcnt != CNT_MAX)
                pcnt <= pcnt + CNT_W'(1);

            if (rise)
                hcnt <= CNT_W'(1);
            else if (s2 && hcnt != CNT_MAX)
                hcnt <= hcnt + CNT_W'(1);

            if (!en) begin
                state    <= IDLE;
                locked   <= 1'b0;
                stall    <= 1'b0;
                good_cnt <= '0;
            end else begin
                case (state)
                    IDLE: state <= ACQ;
                    ACQ: begin
                        if (rise) begin
                            state <= MEAS;
                            stall <= 1'b0;
                        end
                    end
                    MEAS, LOCK: begin
                        // A rise in the timeout cycle wins over the timeout.
                        if (rise) begin
                            period    <= pcnt;
                            high_time <= hcnt;
                            if (meas_bad) begin
                                err      <= 1'b1;
                                if (err_cnt != ERR_MAX)
                                    err_cnt <= err_cnt + ERR_W'(1);
                                good_cnt <= '0;
                                locked   <= 1'b0;
                                state    <= MEAS;
                            end else begin
                                good_cnt <= good_nxt;
                                if (good_nxt == LOCK_C) begin
                                    state  <= LOCK;
                                    locked <= 1'b1;
                                end
                            end
                        end else if (pcnt == TIMEOUT_C) begin
                            // Leaving to ACQ guarantees a single report per stall.
                            err      <= 1'b1;
                            if (err_cnt != ERR_MAX)
                                err_cnt <= err_cnt + ERR_W'(1);
                            stall    <= 1'b1;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            state    <= ACQ;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_clk_mon.sv
module tb_div_clk_mon;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       clk_div_in;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       locked;
    logic       err;
    logic       stall;
    logic [7:0] err_cnt;

    int vectors;
    int miscompares;
    int err_total;
    int snap;

    div_clk_mon #(.DIV(9), .CNT_W(8), .LOCK_CNT(4), .ERR_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .clk_div_in (clk_div_in),
        .period     (period),
        .high_time  (high_time),
        .locked     (locked),
        .err        (err),
        .stall      (stall),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial err_total = 0;
    always @(negedge clk) begin
        if (err === 1'b1)
            err_total <= err_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One divided-clock period: h cycles high then p-h cycles low, negedge aligned.
    task automatic per(input int h, input int p);
        clk_div_in = 1'b1;
        repeat (h) @(negedge clk);
        clk_div_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},    32'(period),    32'd0);
        check({tag, "_high_time"}, 32'(high_time), 32'd0);
        check({tag, "_locked"},    32'(locked),    32'd0);
        check({tag, "_err"},       32'(err),       32'd0);
        check({tag, "_stall"},     32'(stall),     32'd0);
        check({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b1;
        en          = 1'b0;
        clk_div_in  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b0;
        en   = 1'b1;
        repeat (2) @(negedge clk);

        // Steady divide-by-9: lock on the 5th rise.
        snap = err_total;
        repeat (4) per(4, 9);
        check("lock_before_5th", 32'(locked), 32'd0);
        check("period_pre_lock", 32'(period), 32'd9);
        per(4, 9);
        check("lock_at_5th",     32'(locked),    32'd1);
        check("period_steady",   32'(period),    32'd9);
        check("high_steady",     32'(high_time), 32'd4);
        check("errcnt_steady",   32'(err_cnt),   32'd0);
        per(5, 9);
        per(4, 9);
        check("high_five",       32'(high_time), 32'd5);
        check("lock_hold",       32'(locked),    32'd1);
        check("err_pulses_steady", 32'(err_total - snap), 32'd0);

        // One stretched period of 10.
        snap = err_total;
        per(4, 10);
        per(4, 9);
        check("stretch_period",  32'(period),  32'd10);
        check("stretch_errcnt",  32'(err_cnt), 32'd1);
        check("stretch_unlock",  32'(locked),  32'd0);
        check("stretch_pulses",  32'(err_total - snap), 32'd1);
        repeat (3) per(4, 9);
        check("relock_3_good",   32'(locked), 32'd0);
        per(4, 9);
        check("relock_4_good",   32'(locked), 32'd1);

        // Stall: input held low for 30 cycles.
        snap = err_total;
        repeat (30) @(negedge clk);
        check("stall_set",       32'(stall),   32'd1);
        check("stall_pulses",    32'(err_total - snap), 32'd1);
        check("stall_errcnt",    32'(err_cnt), 32'd2);
        check("stall_unlock",    32'(locked),  32'd0);
        per(4, 9);
        check("stall_cleared",   32'(stall),   32'd0);
        repeat (3) per(4, 9);
        check("stall_relock_4",  32'(locked),  32'd0);
        per(4, 9);
        check("stall_relock_5",  32'(locked),  32'd1);
        check("stall_errcnt_hold", 32'(err_cnt), 32'd2);

        // Asynchronous reset in LOCK: outputs clear before the next clock edge.
        #2 rstn = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        per(4, 9);
        check("post_rst_acq_period", 32'(period), 32'd0);
        per(4, 9);
        check("post_rst_period", 32'(period),    32'd9);
        check("post_rst_high",   32'(high_time), 32'd4);

        // 9-cycle period with 2-cycle high time.
        snap = err_total;
        repeat (5) per(2, 9);
        check("duty_high_time",  32'(high_time), 32'd2);
`ifdef DIV_MON_DUTY_CHK_EN
        check("duty_locked",     32'(locked),  32'd0);
        check("duty_errcnt",     32'(err_cnt), 32'd4);
        check("duty_pulses",     32'(err_total - snap), 32'd4);
`else
        check("duty_locked",     32'(locked),  32'd1);
        check("duty_errcnt",     32'(err_cnt), 32'd0);
        check("duty_pulses",     32'(err_total - snap), 32'd0);
`endif

        // 300 periods of 8: error counter saturates, err keeps pulsing.
        repeat (300) per(4, 8);
        check("sat_errcnt",      32'(err_cnt), 32'd255);
        snap = err_total;
        repeat (3) per(4, 8);
        check("sat_pulses",      32'(err_total - snap), 32'd3);
        check("sat_errcnt_hold", 32'(err_cnt), 32'd255);
        check("sat_period",      32'(period),  32'd8);

        // en=0 forces IDLE, clears lock/stall, holds measurements.
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("dis_locked",      32'(locked),  32'd0);
        check("dis_period_hold", 32'(period),  32'd8);
        check("dis_errcnt_hold", 32'(err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
